// File: rtl/mem_subsys_pkg.sv
// Shared types for the L1D lower-side memory subsystem.
//   wb_entry_t       : one writeback buffer slot {valid, paddr, data}
//   lc_req_t         : request presented to the lower cache {paddr, data, we}
//   wb_issue_state_t : lower-side issue FSM states
package mem_subsys_pkg;

    localparam int PADDR_W = 22;
    localparam int DATA_W  = 64;

    typedef struct packed {
        logic               valid;
        logic [PADDR_W-1:0] paddr;
        logic [DATA_W-1:0]  data;
    } wb_entry_t;

    typedef struct packed {
        logic [PADDR_W-1:0] paddr;
        logic [DATA_W-1:0]  data;
        logic               we;
    } lc_req_t;

    typedef enum logic [1:0] {
        IDLE,
        SEND_RD,
        SEND_WB
    } wb_issue_state_t;

endpackage

// File: rtl/wb_addr_match.sv
// Parallel address compare across all writeback entries.
//   entries      : buffer contents
//   paddr        : address being looked up
//   head, tail   : FIFO pointers (age is measured back from tail)
//   head_locked  : head entry is currently presented on the lower port
//   hit          : some valid entry matches
//   hit_idx      : youngest matching entry
//   hit_unlocked : youngest match may be coalesced into
module wb_addr_match
    import mem_subsys_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  wb_entry_t [DEPTH-1:0] entries,
    input  logic [PADDR_W-1:0]    paddr,
    input  logic [PTR_W-1:0]      head,
    input  logic [PTR_W-1:0]      tail,
    input  logic                  head_locked,
    output logic                  hit,
    output logic [PTR_W-1:0]      hit_idx,
    output logic                  hit_unlocked
);

    logic [DEPTH-1:0] eq;

    for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
        assign eq[i] = entries[i].valid && (entries[i].paddr == paddr);
    end

    // Walk oldest to youngest so the youngest match wins.
    always_comb begin
        logic [PTR_W-1:0] idx;
        hit     = 1'b0;
        hit_idx = '0;
        idx     = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            idx = tail - PTR_W'(k + 1);
            if (eq[idx]) begin
                hit     = 1'b1;
                hit_idx = idx;
            end
        end
    end

    // The head is the oldest entry, so if the youngest match is the locked
    // head there is no other match and the write must allocate.
    assign hit_unlocked = hit && !(head_locked && (hit_idx == head));

endmodule

// File: rtl/l1d_writeback_buffer.sv
// Writeback buffer between the L1D lower-cache port and L2.
// Evictions are absorbed into a FIFO (coalescing on address), read misses
// go down one at a time, and reads that hit a pending writeback are
// answered straight from the buffer.
//   l1_*  : request in from L1D / read response back to L1D
//   lc_*  : request out to lower cache / read response from lower cache
//   wb_count_out : occupied entries, empty_out : fully idle
module l1d_writeback_buffer
    import mem_subsys_pkg::*;
#(
    parameter int PADDR_BITS = PADDR_W,
    parameter int WB_DEPTH   = 4,
    parameter int CNT_W      = $clog2(WB_DEPTH + 1)
) (
    input  logic                  clk_in,
    input  logic                  rst_N_in,
    input  logic                  l1_valid_in,
    output logic                  l1_ready_out,
    input  logic [PADDR_BITS-1:0] l1_addr_in,
    input  logic [63:0]           l1_value_in,
    input  logic                  l1_we_in,
    output logic                  l1_valid_out,
    input  logic                  l1_ready_in,
    output logic [PADDR_BITS-1:0] l1_addr_out,
    output logic [63:0]           l1_value_out,
    output logic                  lc_valid_out,
    input  logic                  lc_ready_in,
    output logic [PADDR_BITS-1:0] lc_addr_out,
    output logic [63:0]           lc_value_out,
    output logic                  lc_we_out,
    input  logic                  lc_valid_in,
    output logic                  lc_ready_out,
    input  logic [PADDR_BITS-1:0] lc_addr_in,
    input  logic [63:0]           lc_value_in,
    output logic [CNT_W-1:0]      wb_count_out,
    output logic                  empty_out
);

    localparam int PTR_W = $clog2(WB_DEPTH);

    wb_entry_t [WB_DEPTH-1:0] mem;
    logic [PTR_W-1:0]         head, tail;
    logic [CNT_W-1:0]         count;
    logic                     rd_busy, rd_issued;
    logic [PADDR_BITS-1:0]    rd_addr;
    logic                     resp_valid;
    logic [PADDR_BITS-1:0]    resp_addr;
    logic [63:0]              resp_data;
    wb_issue_state_t          state, state_nxt;
    lc_req_t                  lc_req;

    logic             m_hit, m_hit_unlocked;
    logic [PTR_W-1:0] m_idx;
    logic             head_locked, full, wr_acc, rd_acc, push, pop, rd_sent, resp_acc;

    // The head is only ever popped from SEND_WB, so lock it for exactly that state.
    assign head_locked  = (state == SEND_WB);
    assign full         = (count == CNT_W'(WB_DEPTH));
    assign l1_ready_out = l1_we_in ? !full : (!rd_busy && !resp_valid);
    assign wr_acc       = l1_valid_in && l1_ready_out && l1_we_in;
    assign rd_acc       = l1_valid_in && l1_ready_out && !l1_we_in;
    assign push         = wr_acc && !m_hit_unlocked;
    assign pop          = (state == SEND_WB) && lc_ready_in;
    assign rd_sent      = (state == SEND_RD) && lc_ready_in;
    assign lc_ready_out = !resp_valid;
    assign resp_acc     = lc_valid_in && lc_ready_out;

    wb_addr_match #(.DEPTH(WB_DEPTH), .PTR_W(PTR_W)) u_match (
        .entries      (mem),
        .paddr        (l1_addr_in),
        .head         (head),
        .tail         (tail),
        .head_locked  (head_locked),
        .hit          (m_hit),
        .hit_idx      (m_idx),
        .hit_unlocked (m_hit_unlocked)
    );

    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) begin
            mem        <= '0;
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            rd_busy    <= 1'b0;
            rd_issued  <= 1'b0;
            rd_addr    <= '0;
            resp_valid <= 1'b0;
            resp_addr  <= '0;
            resp_data  <= '0;
        end else begin
            if (wr_acc) begin
                if (m_hit_unlocked) begin
                    mem[m_idx].data <= l1_value_in;
                end else begin
                    mem[tail] <= '{valid: 1'b1, paddr: l1_addr_in, data: l1_value_in};
                    tail      <= tail + 1'b1;
                end
            end
            // Pop and push never touch the same slot: a full buffer takes no writes.
            if (pop) begin
                mem[head].valid <= 1'b0;
                head            <= head + 1'b1;
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);

            if (rd_sent) rd_issued <= 1'b1;
            if (resp_valid && l1_ready_in) resp_valid <= 1'b0;

            // Forward and lc response are mutually exclusive: both need !resp_valid,
            // and a forward additionally needs !rd_busy.
            if (rd_acc) begin
                if (m_hit) begin
                    resp_valid <= 1'b1;
                    resp_addr  <= l1_addr_in;
                    resp_data  <= mem[m_idx].data;
                end else begin
                    rd_busy   <= 1'b1;
                    rd_issued <= 1'b0;
                    rd_addr   <= l1_addr_in;
                end
            end
            if (resp_acc) begin
                resp_valid <= 1'b1;
                resp_addr  <= lc_addr_in;
                resp_data  <= lc_value_in;
                rd_busy    <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) state <= IDLE;
        else           state <= state_nxt;
    end

    // Writeback payload is read live from the head slot; the head is locked
    // while presented so it cannot change under the handshake.
    always_comb begin
        state_nxt    = state;
        lc_req       = '0;
        lc_valid_out = 1'b0;
        unique case (state)
            IDLE: begin
                if (full)                        state_nxt = SEND_WB;
                else if (rd_busy && !rd_issued)  state_nxt = SEND_RD;
                else if (count != '0)            state_nxt = SEND_WB;
            end
            SEND_RD: begin
                lc_valid_out = 1'b1;
                lc_req.paddr = rd_addr;
                if (lc_ready_in) state_nxt = IDLE;
            end
            SEND_WB: begin
                lc_valid_out = 1'b1;
                lc_req.paddr = mem[head].paddr;
                lc_req.data  = mem[head].data;
                lc_req.we    = 1'b1;
                if (lc_ready_in) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign lc_addr_out  = lc_req.paddr;
    assign lc_value_out = lc_req.data;
    assign lc_we_out    = lc_req.we;
    assign l1_valid_out = resp_valid;
    assign l1_addr_out  = resp_addr;
    assign l1_value_out = resp_data;
    assign wb_count_out = count;
    assign empty_out    = (count == '0) && !rd_busy && !resp_valid;

endmodule

// File: tb/tb_l1d_writeback_buffer.sv
module tb_l1d_writeback_buffer;

    localparam int PADDR_BITS = 22;
    localparam int WB_DEPTH   = 4;
    localparam int CNT_W      = $clog2(WB_DEPTH + 1);

    logic                  clk_in, rst_N_in;
    logic                  l1_valid_in, l1_ready_out, l1_we_in;
    logic [PADDR_BITS-1:0] l1_addr_in;
    logic [63:0]           l1_value_in;
    logic                  l1_valid_out, l1_ready_in;
    logic [PADDR_BITS-1:0] l1_addr_out;
    logic [63:0]           l1_value_out;
    logic                  lc_valid_out, lc_ready_in, lc_we_out;
    logic [PADDR_BITS-1:0] lc_addr_out;
    logic [63:0]           lc_value_out;
    logic                  lc_valid_in, lc_ready_out;
    logic [PADDR_BITS-1:0] lc_addr_in;
    logic [63:0]           lc_value_in;
    logic [CNT_W-1:0]      wb_count_out;
    logic                  empty_out;

    l1d_writeback_buffer #(.PADDR_BITS(PADDR_BITS), .WB_DEPTH(WB_DEPTH)) dut (
        .clk_in(clk_in), .rst_N_in(rst_N_in),
        .l1_valid_in(l1_valid_in), .l1_ready_out(l1_ready_out), .l1_addr_in(l1_addr_in),
        .l1_value_in(l1_value_in), .l1_we_in(l1_we_in),
        .l1_valid_out(l1_valid_out), .l1_ready_in(l1_ready_in),
        .l1_addr_out(l1_addr_out), .l1_value_out(l1_value_out),
        .lc_valid_out(lc_valid_out), .lc_ready_in(lc_ready_in), .lc_addr_out(lc_addr_out),
        .lc_value_out(lc_value_out), .lc_we_out(lc_we_out),
        .lc_valid_in(lc_valid_in), .lc_ready_out(lc_ready_out),
        .lc_addr_in(lc_addr_in), .lc_value_in(lc_value_in),
        .wb_count_out(wb_count_out), .empty_out(empty_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    // Reference model: ordered list of pending writebacks, one read slot,
    // one response slot, and a lower cache whose data is a function of address.
    typedef struct { logic [PADDR_BITS-1:0] a; logic [63:0] d; } ent_t;
    ent_t                  q[$];
    bit                    rd_pend, rd_sent, rsp_pend, armed;
    logic [PADDR_BITS-1:0] rd_a, rsp_a, arm_addr;
    logic [63:0]           rsp_d;
    int                    rwait;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] lower_data(input logic [PADDR_BITS-1:0] a);
        return {20'hC0DE5, 22'h0, a};
    endfunction

    function automatic int youngest(input logic [PADDR_BITS-1:0] a);
        int r = -1;
        foreach (q[j]) if (q[j].a == a) r = j;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wr(input logic [PADDR_BITS-1:0] a, input logic [63:0] d);
        l1_valid_in = 1'b1; l1_we_in = 1'b1; l1_addr_in = a; l1_value_in = d;
        #1;
        chk("wr_ready", 64'(l1_ready_out), 64'd1);
        tick();
        l1_valid_in = 1'b0;
    endtask

    task automatic rd(input logic [PADDR_BITS-1:0] a);
        l1_valid_in = 1'b1; l1_we_in = 1'b0; l1_addr_in = a;
        #1;
        chk("rd_ready", 64'(l1_ready_out), 64'd1);
        tick();
        l1_valid_in = 1'b0;
    endtask

    task automatic wait_lc();
        for (int n = 0; n < 10 && !lc_valid_out; n++) tick();
        chk("lc_valid_timeout", 64'(lc_valid_out), 64'd1);
    endtask

    task automatic drain_one(input string tag, input logic [PADDR_BITS-1:0] a, input logic [63:0] d);
        wait_lc();
        chk({tag, "_we"}, 64'(lc_we_out), 64'd1);
        chk({tag, "_addr"}, 64'(lc_addr_out), 64'(a));
        chk({tag, "_data"}, lc_value_out, d);
        lc_ready_in = 1'b1;
        tick();
        lc_ready_in = 1'b0;
    endtask

    // One randomized cycle: drive at negedge, check against the model,
    // then advance the model by the handshakes that the next edge takes.
    task automatic rcycle(input bit drain);
        int  j;
        bit  lock, wacc, racc, pop, riss, lresp, l1hs;
        @(negedge clk_in);
        if (drain) begin
            l1_valid_in = 1'b0; lc_ready_in = 1'b1; l1_ready_in = 1'b1;
        end else begin
            l1_valid_in = ($urandom_range(0, 2) != 0);
            l1_we_in    = 1'($urandom_range(0, 1));
            l1_addr_in  = 22'h100 + 22'($urandom_range(0, 5));
            l1_value_in = {$urandom, $urandom};
            lc_ready_in = ($urandom_range(0, 3) != 0);
            l1_ready_in = ($urandom_range(0, 2) != 0);
        end
        lc_valid_in = armed && (rwait == 0);
        lc_addr_in  = arm_addr;
        lc_value_in = lower_data(arm_addr);
        #1;
        chk("r_count", 64'(wb_count_out), 64'(q.size()));
        chk("r_empty", 64'(empty_out), 64'(q.size() == 0 && !rd_pend && !rsp_pend));
        chk("r_l1_ready", 64'(l1_ready_out),
            64'(l1_we_in ? (q.size() < WB_DEPTH) : (!rd_pend && !rsp_pend)));
        chk("r_lc_ready", 64'(lc_ready_out), 64'(!rsp_pend));
        chk("r_l1_valid", 64'(l1_valid_out), 64'(rsp_pend));
        if (rsp_pend) begin
            chk("r_l1_addr", 64'(l1_addr_out), 64'(rsp_a));
            chk("r_l1_value", l1_value_out, rsp_d);
        end
        if (lc_valid_out && lc_we_out) begin
            chk("r_wb_pending", 64'(q.size() != 0), 64'd1);
            if (q.size() != 0) begin
                chk("r_wb_addr", 64'(lc_addr_out), 64'(q[0].a));
                chk("r_wb_data", lc_value_out, q[0].d);
            end
        end
        if (lc_valid_out && !lc_we_out) begin
            chk("r_rd_pending", 64'(rd_pend && !rd_sent), 64'd1);
            chk("r_rd_addr", 64'(lc_addr_out), 64'(rd_a));
        end

        lock  = lc_valid_out && lc_we_out;
        wacc  = l1_valid_in && l1_we_in && (q.size() < WB_DEPTH);
        racc  = l1_valid_in && !l1_we_in && !rd_pend && !rsp_pend;
        pop   = lc_valid_out && lc_we_out && lc_ready_in;
        riss  = lc_valid_out && !lc_we_out && lc_ready_in;
        lresp = lc_valid_in && !rsp_pend;
        l1hs  = rsp_pend && l1_ready_in;

        if (l1hs) rsp_pend = 1'b0;
        if (racc) begin
            j = youngest(l1_addr_in);
            if (j >= 0) begin
                rsp_pend = 1'b1; rsp_a = l1_addr_in; rsp_d = q[j].d;
            end else begin
                rd_pend = 1'b1; rd_sent = 1'b0; rd_a = l1_addr_in;
            end
        end
        if (wacc) begin
            j = youngest(l1_addr_in);
            if (j >= 0 && !(j == 0 && lock)) q[j].d = l1_value_in;
            else q.push_back('{a: l1_addr_in, d: l1_value_in});
        end
        if (pop) void'(q.pop_front());
        if (lresp) begin
            rsp_pend = 1'b1; rsp_a = lc_addr_in; rsp_d = lc_value_in;
            rd_pend = 1'b0; armed = 1'b0;
        end else if (armed && rwait > 0) begin
            rwait--;
        end
        if (riss) begin
            rd_sent = 1'b1; armed = 1'b1; arm_addr = lc_addr_out;
            rwait = $urandom_range(0, 3);
        end
    endtask

    initial begin
        rst_N_in = 1'b0;
        l1_valid_in = 1'b0; l1_we_in = 1'b0; l1_addr_in = '0; l1_value_in = '0;
        l1_ready_in = 1'b0; lc_ready_in = 1'b0;
        lc_valid_in = 1'b0; lc_addr_in = '0; lc_value_in = '0;
        rd_pend = 0; rd_sent = 0; rsp_pend = 0; armed = 0; rwait = 0;
        rd_a = '0; rsp_a = '0; rsp_d = '0; arm_addr = '0;

        // Reset state
        #12;
        chk("rst_lc_valid", 64'(lc_valid_out), 64'd0);
        chk("rst_l1_valid", 64'(l1_valid_out), 64'd0);
        chk("rst_count", 64'(wb_count_out), 64'd0);
        chk("rst_empty", 64'(empty_out), 64'd1);
        chk("rst_rd_ready", 64'(l1_ready_out), 64'd1);
        rst_N_in = 1'b1;
        tick();

        // Single writeback, held until accepted
        wr(22'h1000, 64'hAA);
        chk("t1_count", 64'(wb_count_out), 64'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t1_hold_valid", 64'(lc_valid_out), 64'd1);
            chk("t1_hold_we", 64'(lc_we_out), 64'd1);
            chk("t1_hold_addr", 64'(lc_addr_out), 64'h1000);
            chk("t1_hold_data", lc_value_out, 64'hAA);
        end
        chk("t1_count_held", 64'(wb_count_out), 64'd1);
        lc_ready_in = 1'b1;
        tick();
        lc_ready_in = 1'b0;
        chk("t1_count_after", 64'(wb_count_out), 64'd0);
        chk("t1_empty", 64'(empty_out), 64'd1);

        // Coalescing behind a locked head
        wr(22'h2000, 64'h1);
        wr(22'h1000, 64'h11);
        wr(22'h1000, 64'h22);
        chk("t2_count", 64'(wb_count_out), 64'd2);
        drain_one("t2_first", 22'h2000, 64'h1);
        drain_one("t2_second", 22'h1000, 64'h22);
        chk("t2_empty", 64'(empty_out), 64'd1);

        // Read forwarded from a pending writeback
        wr(22'h3000, 64'hBEEF);
        rd(22'h3000);
        chk("t3_l1_valid", 64'(l1_valid_out), 64'd1);
        chk("t3_l1_addr", 64'(l1_addr_out), 64'h3000);
        chk("t3_l1_value", l1_value_out, 64'hBEEF);
        chk("t3_no_lc_read", 64'(lc_we_out), 64'd1);
        l1_ready_in = 1'b1;
        tick();
        l1_ready_in = 1'b0;
        chk("t3_l1_valid_clr", 64'(l1_valid_out), 64'd0);
        drain_one("t3_wb", 22'h3000, 64'hBEEF);

        // Read miss issued ahead of a queued writeback
        wr(22'h6000, 64'h66);
        wr(22'h5000, 64'h55);
        rd(22'h4000);
        #1;
        chk("t4_rd_stall", 64'(l1_ready_out), 64'd0);
        drain_one("t4_wb6", 22'h6000, 64'h66);
        wait_lc();
        chk("t4_rd_we", 64'(lc_we_out), 64'd0);
        chk("t4_rd_addr", 64'(lc_addr_out), 64'h4000);
        lc_ready_in = 1'b1;
        tick();
        lc_ready_in = 1'b0;
        lc_valid_in = 1'b1; lc_addr_in = 22'h4000; lc_value_in = 64'h77;
        #1;
        chk("t4_lc_ready", 64'(lc_ready_out), 64'd1);
        tick();
        lc_valid_in = 1'b0;
        chk("t4_l1_valid", 64'(l1_valid_out), 64'd1);
        chk("t4_l1_addr", 64'(l1_addr_out), 64'h4000);
        chk("t4_l1_value", l1_value_out, 64'h77);
        chk("t4_rd_stall2", 64'(l1_ready_out), 64'd0);
        l1_ready_in = 1'b1;
        tick();
        l1_ready_in = 1'b0;
        #1;
        chk("t4_rd_ready", 64'(l1_ready_out), 64'd1);
        drain_one("t4_wb5", 22'h5000, 64'h55);
        chk("t4_empty", 64'(empty_out), 64'd1);

        // Full buffer
        for (int i = 0; i < 4; i++) wr(22'h7000 + 22'(i), 64'h70 + 64'(i));
        chk("t5_count", 64'(wb_count_out), 64'd4);
        l1_we_in = 1'b1;
        #1;
        chk("t5_full_wr_ready", 64'(l1_ready_out), 64'd0);
        rd(22'h8000);
        drain_one("t5_wb0", 22'h7000, 64'h70);
        wait_lc();
        chk("t5_rd_we", 64'(lc_we_out), 64'd0);
        chk("t5_rd_addr", 64'(lc_addr_out), 64'h8000);
        lc_ready_in = 1'b1;
        tick();
        lc_ready_in = 1'b0;
        lc_valid_in = 1'b1; lc_addr_in = 22'h8000; lc_value_in = 64'h88;
        tick();
        lc_valid_in = 1'b0;
        chk("t5_l1_valid", 64'(l1_valid_out), 64'd1);
        chk("t5_l1_value", l1_value_out, 64'h88);
        chk("t5_lc_valid", 64'(lc_valid_out), 64'd1);
        chk("t5_lc_addr", 64'(lc_addr_out), 64'h7001);

        // Asynchronous reset in the middle of SEND_WB
        #2;
        rst_N_in = 1'b0;
        #1;
        chk("t6_lc_valid", 64'(lc_valid_out), 64'd0);
        chk("t6_lc_addr", 64'(lc_addr_out), 64'd0);
        chk("t6_lc_value", lc_value_out, 64'd0);
        chk("t6_lc_we", 64'(lc_we_out), 64'd0);
        chk("t6_l1_valid", 64'(l1_valid_out), 64'd0);
        chk("t6_l1_addr", 64'(l1_addr_out), 64'd0);
        chk("t6_l1_value", l1_value_out, 64'd0);
        chk("t6_count", 64'(wb_count_out), 64'd0);
        chk("t6_empty", 64'(empty_out), 64'd1);
        #3;
        rst_N_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_post_lc_valid", 64'(lc_valid_out), 64'd0);
            chk("t6_post_count", 64'(wb_count_out), 64'd0);
        end

        // Randomized traffic against the reference model, then drain
        for (int i = 0; i < 3000; i++) rcycle(1'b0);
        for (int i = 0; i < 80; i++) rcycle(1'b1);
        #1;
        chk("final_empty", 64'(empty_out), 64'd1);
        chk("final_model_empty", 64'(q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
